// File: rtl/mux_n_pipe.sv
// rtl/mux_n_pipe.sv - N:1 select mux with registered, skid-buffered handshaked output (optional sel_err via MUX_N_PIPE_SEL_ERR_EN)
module mux_n_pipe #(
    parameter int WIDTH  = 5,
    parameter int NUM_IN = 3,
    parameter int SEL_W  = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_IN*WIDTH-1:0] inp,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        out,
    output logic                    out_valid,
    input  logic                    out_ready
`ifdef MUX_N_PIPE_SEL_ERR_EN
    ,
    output logic                    sel_err
`endif
);

    // State encoding is {out_valid, skid_full}, so both flags fall straight out of the register.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b10,
        ST_FULL  = 2'b11
    } state_t;

    localparam logic [31:0] NUM_IN_U = 32'(NUM_IN);

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  out_q, out_d;
    logic [WIDTH-1:0]  skid_q, skid_d;
    logic [WIDTH-1:0]  sel_data;
    logic [31:0]       sel_ext;
    logic              sel_in_range;
    logic              accept;
    logic              consume;

    // Handshake flags: in_ready depends only on registered state (and reset), never on out_ready.
    always_comb begin
        out_valid = state_q[1];
        in_ready  = !state_q[0] && !rst;
        out       = out_q;
        accept    = in_valid && in_ready;
        consume   = out_valid && out_ready;
    end

    // Input select; out-of-range codes clamp to the last input so out is never X.
    always_comb begin
        sel_ext      = 32'(sel);
        sel_in_range = (sel_ext < NUM_IN_U);
        sel_data     = inp[(NUM_IN-1)*WIDTH +: WIDTH];
        for (int k = 0; k < NUM_IN; k++) begin
            if (sel_in_range && (sel_ext == 32'(k))) begin
                sel_data = inp[k*WIDTH +: WIDTH];
            end
        end
    end

    // Next-state: output register plus one skid entry, strictly FIFO.
    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    out_d   = sel_data;
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (accept && consume) begin
                    out_d = sel_data;
                end else if (accept) begin
                    skid_d  = sel_data;
                    state_d = ST_FULL;
                end else if (consume) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (consume) begin
                    out_d   = skid_q;
                    state_d = ST_ONE;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
    end

    // Pipeline registers; reset discards both the output and skid contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            out_q   <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            skid_q  <= skid_d;
        end
    end

`ifdef MUX_N_PIPE_SEL_ERR_EN
    logic sel_err_q, sel_err_d;

    // Sticky flag for any accepted out-of-range select.
    always_comb begin
        sel_err_d = sel_err_q || (accept && !sel_in_range);
        sel_err   = sel_err_q;
    end

    // Sticky flag register, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_err_q <= 1'b0;
        end else begin
            sel_err_q <= sel_err_d;
        end
    end
`endif

endmodule
